emesh_packet_arb: RTL



---
 rtl/emesh_packet_arb.sv | 102 ++++++++++
 1 files changed

// File: rtl/emesh_packet_arb.sv
// N-to-1 emesh packet arbiter with a single-entry registered output stage.
// Define EMESH_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module emesh_packet_arb #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 104
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    access_in,
    input  logic [N*PW-1:0] packet_in,
    output logic [N-1:0]    wait_out,
    output logic            access_out,
    output logic [PW-1:0]   packet_out,
    input  logic            wait_in,
    output logic [N-1:0]    grant_out
);

    localparam int unsigned PTRW = $clog2(N);
    localparam int unsigned SW   = PTRW + 1;

    logic                   w_ready;
    logic                   w_found;
    logic [PTRW-1:0]        w_idx;
    logic [N-1:0]           w_grant;
    logic [N-1:0][PW-1:0]   w_pkts;
    logic                   r_access;
    logic [PW-1:0]          r_packet;

    assign w_pkts  = packet_in;
    assign w_ready = ~r_access | ~wait_in;

`ifdef EMESH_ARB_RR_EN
    logic [PTRW-1:0] r_ptr;
    logic [SW-1:0]   w_nxt;

    // First active requester searching upward from r_ptr, wrapping mod N.
    always_comb begin : arb
        logic [SW-1:0] v_sum;
        w_found = 1'b0;
        w_idx   = '0;
        v_sum   = '0;
        for (int unsigned off = 0; off < N; off++) begin
            v_sum = SW'(r_ptr) + SW'(off);
            if (v_sum >= SW'(N)) begin
                v_sum = v_sum - SW'(N);
            end
            if (!w_found && access_in[v_sum[PTRW-1:0]]) begin
                w_found = 1'b1;
                w_idx   = v_sum[PTRW-1:0];
            end
        end
    end

    assign w_nxt = SW'(w_idx) + SW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (|w_grant) begin
            r_ptr <= (w_nxt == SW'(N)) ? '0 : w_nxt[PTRW-1:0];
        end
    end
`else
    // Lowest active index wins; no history.
    always_comb begin : arb
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_found && access_in[PTRW'(i)]) begin
                w_found = 1'b1;
                w_idx   = PTRW'(i);
            end
        end
    end
`endif

    always_comb begin
        w_grant = '0;
        if (!reset && w_ready && w_found) begin
            w_grant[w_idx] = 1'b1;
        end
    end

    // Output stage loads whenever it is empty or being drained this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_access <= 1'b0;
            r_packet <= '0;
        end else if (w_ready) begin
            r_access <= |w_grant;
            if (|w_grant) begin
                r_packet <= w_pkts[w_idx];
            end
        end
    end

    assign grant_out  = w_grant;
    assign wait_out   = reset ? '1 : (access_in & ~w_grant);
    assign access_out = r_access;
    assign packet_out = r_packet;

endmodule
